// File: rtl/axi_from_lite_upsize_if.sv
// AXI-Lite and full AXI channel bundles shared by the Lite-to-AXI bridge.
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    aw_valid, aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid, w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid, b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    ar_valid, ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid, r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );
  modport slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

interface axi_channel #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid, aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid, w_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid, b_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid, ar_ready;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid, r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
    input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );
  modport slave (
    input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
          aw_qos, aw_region, aw_user, aw_valid, output aw_ready,
    input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
          ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_from_lite_upsize.sv
// AXI-Lite to AXI bridge: steers narrow Lite beats into the addressed lane of a
// wider AXI bus, remembering each outstanding transaction's lane in small FIFOs.
module axi_from_lite_upsize_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

module axi_from_lite_upsize #(
  parameter int ADDR_WIDTH      = 48,
  parameter int LITE_DATA_WIDTH = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic      clk,
  input logic      rst,
  axi_lite_channel.slave master,
  axi_channel.master     slave
);
  localparam int RATIO  = DATA_WIDTH / LITE_DATA_WIDTH;
  localparam int LB     = $clog2(LITE_DATA_WIDTH / 8);
  localparam int AB     = $clog2(DATA_WIDTH / 8);
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LSTRB  = LITE_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  if ($bits(master.aw_addr) != ADDR_WIDTH || $bits(slave.aw_addr) != ADDR_WIDTH) begin : g_bad_addr
    $fatal(1, "axi_from_lite_upsize: interface ADDR_WIDTH mismatch");
  end
  if ($bits(master.w_data) != LITE_DATA_WIDTH || $bits(slave.w_data) != DATA_WIDTH) begin : g_bad_data
    $fatal(1, "axi_from_lite_upsize: interface data width mismatch");
  end
  if (DATA_WIDTH < LITE_DATA_WIDTH) begin : g_bad_ratio
    $fatal(1, "axi_from_lite_upsize: DATA_WIDTH must be >= LITE_DATA_WIDTH");
  end

  logic [LANE_W-1:0]       aw_lane, ar_lane, wq_head, rq_head;
  logic                    wq_empty, wq_full, rq_empty, rq_full;
  logic [CNT_W-1:0]        wcnt;
  logic                    wcnt_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [DATA_WIDTH/8-1:0] w_strb;

  assign wcnt_ok = (wcnt < CNT_W'(MAX_OUTSTANDING));
  assign aw_hs   = master.aw_valid && slave.aw_ready && wcnt_ok;
  assign w_hs    = master.w_valid && slave.w_ready && !wq_empty;
  assign b_hs    = slave.b_valid && master.b_ready;
  assign ar_hs   = master.ar_valid && slave.ar_ready && !rq_full;
  assign r_hs    = slave.r_valid && master.r_ready;

  axi_from_lite_upsize_lane_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(LANE_W)) u_wq (
    .clk(clk), .rst(rst), .push(aw_hs), .pop(w_hs), .din(aw_lane),
    .head(wq_head), .empty(wq_empty), .full(wq_full)
  );
  axi_from_lite_upsize_lane_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(LANE_W)) u_rq (
    .clk(clk), .rst(rst), .push(ar_hs), .pop(r_hs), .din(ar_lane),
    .head(rq_head), .empty(rq_empty), .full(rq_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wcnt <= '0;
    else if (aw_hs && !b_hs) wcnt <= wcnt + 1'b1;
    else if (!aw_hs && b_hs && wcnt != '0) wcnt <= wcnt - 1'b1;
  end

  // Write/read lanes: narrow beats are steered by the address bits above the Lite word.
  if (RATIO > 1) begin : g_steer
    logic [LANE_W-1:0] r_lane;
    assign aw_lane = master.aw_addr[AB-1:LB];
    assign ar_lane = master.ar_addr[AB-1:LB];
    assign r_lane  = rq_empty ? '0 : rq_head;
    always_comb begin
      w_strb = '0;
      w_strb[int'(wq_head)*LSTRB +: LSTRB] = master.w_strb;
    end
    assign master.r_data = slave.r_data[int'(r_lane)*LITE_DATA_WIDTH +: LITE_DATA_WIDTH];
  end else begin : g_pass
    assign aw_lane       = '0;
    assign ar_lane       = '0;
    assign w_strb        = master.w_strb;
    assign master.r_data = slave.r_data;
  end

  assign slave.aw_id     = '0;
  assign slave.aw_addr   = master.aw_addr;
  assign slave.aw_len    = '0;
  assign slave.aw_size   = 3'(LB);
  assign slave.aw_burst  = 2'b01;
  assign slave.aw_lock   = 1'b0;
  assign slave.aw_cache  = '0;
  assign slave.aw_prot   = master.aw_prot;
  assign slave.aw_qos    = '0;
  assign slave.aw_region = '0;
  assign slave.aw_user   = '0;
  assign slave.aw_valid  = master.aw_valid && wcnt_ok;
  assign master.aw_ready = slave.aw_ready && wcnt_ok;

  assign slave.w_data    = {RATIO{master.w_data}};
  assign slave.w_strb    = w_strb;
  assign slave.w_last    = 1'b1;
  assign slave.w_user    = '0;
  assign slave.w_valid   = master.w_valid && !wq_empty;
  assign master.w_ready  = slave.w_ready && !wq_empty;

  assign master.b_resp   = slave.b_resp;
  assign master.b_valid  = slave.b_valid;
  assign slave.b_ready   = master.b_ready;

  assign slave.ar_id     = '0;
  assign slave.ar_addr   = master.ar_addr;
  assign slave.ar_len    = '0;
  assign slave.ar_size   = 3'(LB);
  assign slave.ar_burst  = 2'b01;
  assign slave.ar_lock   = 1'b0;
  assign slave.ar_cache  = '0;
  assign slave.ar_prot   = master.ar_prot;
  assign slave.ar_qos    = '0;
  assign slave.ar_region = '0;
  assign slave.ar_user   = '0;
  assign slave.ar_valid  = master.ar_valid && !rq_full;
  assign master.ar_ready = slave.ar_ready && !rq_full;

  assign master.r_resp   = slave.r_resp;
  assign master.r_valid  = slave.r_valid;
  assign slave.r_ready   = master.r_ready;

  logic unused_sigs;
  assign unused_sigs = ^{slave.b_id, slave.b_user, slave.r_id, slave.r_last, slave.r_user,
                         wq_head, rq_head, wq_full};

  ap_r_without_ar: assert property (@(posedge clk) disable iff (rst) !(slave.r_valid && rq_empty));
  ap_b_without_aw: assert property (@(posedge clk) disable iff (rst) !(slave.b_valid && wcnt == '0));
endmodule

// File: tb/tb_axi_from_lite_upsize.sv
// Bench for the Lite-to-AXI upsizing bridge: directed scenarios plus random traffic
// compared against a queue-based reference model of outstanding lanes.
module tb_axi_from_lite_upsize;
  localparam int AW   = 48;
  localparam int LDW  = 32;
  localparam int DW   = 64;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(LDW)) lm ();
  axi_channel      #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW))  sa ();
  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW))  lm1 ();
  axi_channel      #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW))  sa1 ();

  axi_from_lite_upsize #(.ADDR_WIDTH(AW), .LITE_DATA_WIDTH(LDW), .DATA_WIDTH(DW),
                         .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .master(lm), .slave(sa));
  axi_from_lite_upsize #(.ADDR_WIDTH(AW), .LITE_DATA_WIDTH(DW), .DATA_WIDTH(DW),
                         .MAX_OUTSTANDING(MAXO)) dut1 (
    .clk(clk), .rst(rst), .master(lm1), .slave(sa1));

  int checks = 0;
  int failures = 0;

  // Reference state: lane of every accepted-but-unfinished beat, and accepted-but-unanswered writes.
  int unsigned wq[$];
  int unsigned rq[$];
  int          wcnt = 0;
  logic        last_ar_hs;

  function automatic int unsigned lane_of(input logic [AW-1:0] a);
    return int'((a >> 2) % (DW / LDW));
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag);
    logic [30:0] attr_exp;
    logic [63:0] rd;
    logic [7:0]  se;
    int unsigned ln;
    attr_exp = {4'd0, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
    chk({tag, ".aw_valid"}, sa.aw_valid, lm.aw_valid && (wcnt < MAXO));
    chk({tag, ".aw_ready"}, lm.aw_ready, sa.aw_ready && (wcnt < MAXO));
    chk({tag, ".aw_addr"}, sa.aw_addr, lm.aw_addr);
    chk({tag, ".aw_prot"}, sa.aw_prot, lm.aw_prot);
    chk({tag, ".aw_attr"}, {sa.aw_id, sa.aw_len, sa.aw_size, sa.aw_burst, sa.aw_lock,
                            sa.aw_cache, sa.aw_qos, sa.aw_region, sa.aw_user}, attr_exp);
    chk({tag, ".w_valid"}, sa.w_valid, lm.w_valid && (wq.size() > 0));
    chk({tag, ".w_ready"}, lm.w_ready, sa.w_ready && (wq.size() > 0));
    chk({tag, ".w_data"}, sa.w_data, {lm.w_data, lm.w_data});
    chk({tag, ".w_last_user"}, {sa.w_last, sa.w_user}, 2'b10);
    if (wq.size() > 0) begin
      se = 8'(lm.w_strb) << (4 * wq[0]);
      chk({tag, ".w_strb"}, sa.w_strb, se);
    end
    chk({tag, ".b_fwd"}, {lm.b_valid, lm.b_resp, sa.b_ready}, {sa.b_valid, sa.b_resp, lm.b_ready});
    chk({tag, ".ar_valid"}, sa.ar_valid, lm.ar_valid && (rq.size() < MAXO));
    chk({tag, ".ar_ready"}, lm.ar_ready, sa.ar_ready && (rq.size() < MAXO));
    chk({tag, ".ar_addr"}, sa.ar_addr, lm.ar_addr);
    chk({tag, ".ar_prot"}, sa.ar_prot, lm.ar_prot);
    chk({tag, ".ar_attr"}, {sa.ar_id, sa.ar_len, sa.ar_size, sa.ar_burst, sa.ar_lock,
                            sa.ar_cache, sa.ar_qos, sa.ar_region, sa.ar_user}, attr_exp);
    chk({tag, ".r_fwd"}, {lm.r_valid, lm.r_resp, sa.r_ready}, {sa.r_valid, sa.r_resp, lm.r_ready});
    ln = (rq.size() > 0) ? rq[0] : 0;
    rd = sa.r_data >> (LDW * ln);
    chk({tag, ".r_data"}, lm.r_data, rd[31:0]);
  endtask

  task automatic settle(input string tag);
    #1;
    check_main(tag);
  endtask

  task automatic tick();
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    @(posedge clk);
    if (rst) begin
      wq.delete(); rq.delete(); wcnt = 0; last_ar_hs = 1'b0;
    end else begin
      aw_hs = lm.aw_valid && sa.aw_ready && (wcnt < MAXO);
      w_hs  = lm.w_valid && sa.w_ready && (wq.size() > 0);
      b_hs  = sa.b_valid && lm.b_ready;
      ar_hs = lm.ar_valid && sa.ar_ready && (rq.size() < MAXO);
      r_hs  = sa.r_valid && lm.r_ready && (rq.size() > 0);
      if (w_hs) void'(wq.pop_front());
      if (aw_hs) wq.push_back(lane_of(lm.aw_addr));
      if (r_hs) void'(rq.pop_front());
      if (ar_hs) rq.push_back(lane_of(lm.ar_addr));
      wcnt = wcnt + int'(aw_hs) - int'(b_hs);
      last_ar_hs = ar_hs;
    end
    #1;
  endtask

  task automatic idle_main();
    lm.aw_valid = 0; lm.aw_addr = '0; lm.aw_prot = '0;
    lm.w_valid = 0; lm.w_data = '0; lm.w_strb = '0; lm.b_ready = 0;
    lm.ar_valid = 0; lm.ar_addr = '0; lm.ar_prot = '0; lm.r_ready = 0;
    sa.aw_ready = 0; sa.w_ready = 0; sa.b_valid = 0; sa.b_resp = '0; sa.b_id = '0; sa.b_user = '0;
    sa.ar_ready = 0; sa.r_valid = 0; sa.r_data = '0; sa.r_resp = '0;
    sa.r_id = '0; sa.r_last = 0; sa.r_user = '0;
  endtask

  task automatic idle_wide();
    lm1.aw_valid = 0; lm1.aw_addr = '0; lm1.aw_prot = '0;
    lm1.w_valid = 0; lm1.w_data = '0; lm1.w_strb = '0; lm1.b_ready = 0;
    lm1.ar_valid = 0; lm1.ar_addr = '0; lm1.ar_prot = '0; lm1.r_ready = 0;
    sa1.aw_ready = 0; sa1.w_ready = 0; sa1.b_valid = 0; sa1.b_resp = '0; sa1.b_id = '0; sa1.b_user = '0;
    sa1.ar_ready = 0; sa1.r_valid = 0; sa1.r_data = '0; sa1.r_resp = '0;
    sa1.r_id = '0; sa1.r_last = 0; sa1.r_user = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] raddrs [5];
    logic [63:0]   wd;
    raddrs = '{48'h0, 48'h4, 48'h8, 48'hC, 48'h10};
    idle_main();
    idle_wide();
    rst = 1'b1;
    last_ar_hs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lm.ar_valid = 1; sa.ar_ready = 1;
    settle("reset");
    idle_main();
    tick();
    rst = 1'b0;

    // Single write to 0x1004 lands in the upper lane.
    lm.aw_addr = 48'h1004; lm.aw_prot = 3'($urandom); lm.aw_valid = 1;
    lm.w_data = 32'hDEADBEEF; lm.w_strb = 4'hF; lm.w_valid = 1; lm.b_ready = 1;
    sa.aw_ready = 1; sa.w_ready = 1;
    settle("wr_aw");
    chk("wr_aw.size", sa.aw_size, 3'd2);
    tick();
    lm.aw_valid = 0;
    settle("wr_w");
    chk("wr_w.data", sa.w_data, 64'hDEADBEEF_DEADBEEF);
    chk("wr_w.strb", sa.w_strb, 8'hF0);
    chk("wr_w.valid", sa.w_valid, 1'b1);
    tick();
    lm.w_valid = 0; sa.b_valid = 1; sa.b_resp = 2'b00;
    settle("wr_b");
    chk("wr_b.valid", lm.b_valid, 1'b1);
    tick();
    sa.b_valid = 0;

    // W offered before its AW must wait.
    lm.w_valid = 1; lm.w_data = $urandom; lm.w_strb = 4'hF;
    repeat (3) begin
      settle("wfirst_wait");
      chk("wfirst.w_ready", lm.w_ready, 1'b0);
      chk("wfirst.w_valid", sa.w_valid, 1'b0);
      tick();
    end
    lm.aw_addr = 48'h2000; lm.aw_valid = 1;
    settle("wfirst_aw");
    tick();
    lm.aw_valid = 0;
    settle("wfirst_w");
    chk("wfirst.fwd", sa.w_valid, 1'b1);
    chk("wfirst.strb", sa.w_strb, 8'h0F);
    tick();
    lm.w_valid = 0; sa.b_valid = 1;
    settle("wfirst_b");
    tick();
    sa.b_valid = 0;

    // Five reads with R withheld: the fifth stalls until the first beat returns.
    sa.ar_ready = 1; lm.r_ready = 1; lm.ar_valid = 1;
    for (int i = 0; i < 4; i++) begin
      lm.ar_addr = raddrs[i];
      settle("rd_issue");
      chk("rd_issue.ar_ready", lm.ar_ready, 1'b1);
      tick();
    end
    lm.ar_addr = raddrs[4];
    repeat (2) begin
      settle("rd_stall");
      chk("rd_stall.ar_ready", lm.ar_ready, 1'b0);
      tick();
    end
    sa.r_valid = 1; sa.r_data = 64'h11111111_22222222;
    settle("rd_first");
    chk("rd_first.data", lm.r_data, 32'h22222222);
    chk("rd_first.ar_ready", lm.ar_ready, 1'b0);
    tick();
    wd = {$urandom, $urandom}; sa.r_data = wd;
    settle("rd_second");
    chk("rd_fifth.ar_ready", lm.ar_ready, 1'b1);
    chk("rd_second.upper", lm.r_data, wd[63:32]);
    tick();
    lm.ar_valid = 0;
    for (int n = 0; n < 8 && rq.size() > 0; n++) begin
      sa.r_data = {$urandom, $urandom};
      settle("rd_drain");
      tick();
    end
    sa.r_valid = 0;

    // Five AWs with B withheld; B and a new AW coincide at the limit.
    lm.aw_valid = 1;
    for (int i = 0; i < 4; i++) begin
      lm.aw_addr = {16'h0, $urandom} & ~48'h3;
      settle("aw_issue");
      chk("aw_issue.ready", lm.aw_ready, 1'b1);
      tick();
    end
    lm.w_valid = 1; lm.w_strb = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      lm.w_data = $urandom;
      settle("aw_stall");
      chk("aw_stall.ready", lm.aw_ready, 1'b0);
      tick();
    end
    lm.w_valid = 0; sa.b_valid = 1; lm.b_ready = 1;
    settle("aw_b_coincide");
    chk("aw_b.aw_ready", lm.aw_ready, 1'b0);
    chk("aw_b.aw_valid", sa.aw_valid, 1'b0);
    tick();
    sa.b_valid = 0;
    settle("aw_resume");
    chk("aw_resume.ready", lm.aw_ready, 1'b1);
    tick();
    lm.aw_valid = 0; lm.w_valid = 1;
    settle("aw_w_last");
    tick();
    lm.w_valid = 0; sa.b_valid = 1;
    for (int n = 0; n < 8 && wcnt > 0; n++) begin
      settle("aw_b_drain");
      tick();
    end
    sa.b_valid = 0;

    // Reset in the middle of two outstanding reads.
    lm.ar_valid = 1;
    for (int i = 0; i < 2; i++) begin
      lm.ar_addr = raddrs[i];
      settle("rst_issue");
      tick();
    end
    #2;
    rst = 1'b1;
    wq.delete(); rq.delete(); wcnt = 0;
    settle("rst_mid");
    chk("rst_mid.ar_ready", lm.ar_ready, sa.ar_ready);
    tick();
    rst = 1'b0;
    lm.ar_addr = 48'h4;
    settle("rst_rd_ar");
    tick();
    lm.ar_valid = 0; sa.r_valid = 1; wd = {$urandom, $urandom}; sa.r_data = wd;
    settle("rst_rd_r");
    chk("rst_rd.upper", lm.r_data, wd[63:32]);
    tick();
    sa.r_valid = 0;

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      lm.aw_valid = 1'($urandom); lm.aw_addr = {$urandom, $urandom}; lm.aw_prot = 3'($urandom);
      lm.w_valid = 1'($urandom); lm.w_data = $urandom; lm.w_strb = 4'($urandom);
      lm.b_ready = 1'($urandom);
      lm.ar_valid = 1'($urandom); lm.ar_addr = {$urandom, $urandom}; lm.ar_prot = 3'($urandom);
      lm.r_ready = 1'($urandom);
      sa.aw_ready = 1'($urandom); sa.w_ready = 1'($urandom); sa.ar_ready = 1'($urandom);
      sa.b_valid = (wcnt > wq.size()) ? 1'($urandom) : 1'b0;
      sa.b_resp = 2'($urandom); sa.b_id = 4'($urandom); sa.b_user = 1'($urandom);
      sa.r_valid = (rq.size() > 0) ? 1'($urandom) : 1'b0;
      sa.r_data = {$urandom, $urandom}; sa.r_resp = 2'($urandom);
      sa.r_id = 4'($urandom); sa.r_last = 1'($urandom); sa.r_user = 1'($urandom);
      settle("rand");
      tick();
    end
    idle_main();

    // RATIO == 1 instance: everything passes straight through.
    for (int k = 0; k < 3; k++) begin
      lm1.aw_addr = {$urandom, $urandom}; lm1.aw_valid = 1; sa1.aw_ready = 1;
      lm1.w_data = {$urandom, $urandom}; lm1.w_strb = 8'($urandom); lm1.w_valid = 1; sa1.w_ready = 1;
      lm1.ar_addr = {$urandom, $urandom}; lm1.ar_valid = 1; sa1.ar_ready = 1; lm1.r_ready = 1;
      lm1.b_ready = 1;
      #1;
      chk("wide.aw_size", sa1.aw_size, 3'd3);
      chk("wide.ar_size", sa1.ar_size, 3'd3);
      chk("wide.aw_valid", sa1.aw_valid, 1'b1);
      chk("wide.w_wait", sa1.w_valid, 1'b0);
      @(posedge clk); #1;
      lm1.aw_valid = 0; lm1.ar_valid = 0;
      sa1.r_valid = 1; sa1.r_data = {$urandom, $urandom};
      #1;
      chk("wide.w_valid", sa1.w_valid, 1'b1);
      chk("wide.w_data", sa1.w_data, lm1.w_data);
      chk("wide.w_strb", sa1.w_strb, lm1.w_strb);
      chk("wide.r_data", lm1.r_data, sa1.r_data);
      @(posedge clk); #1;
      lm1.w_valid = 0; sa1.r_valid = 0; sa1.b_valid = 1;
      @(posedge clk); #1;
      sa1.b_valid = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_from_lite_upsize.md
Name: axi_from_lite_upsize

Overview:
- Bridge from an AXI-Lite master to an AXI slave.
- The Lite data bus may be narrower than the AXI data bus: write data and strobes are steered into the addressed byte lane, and read data is extracted from the addressed lane.
- Tracks outstanding transactions, using lane FIFOs and counters bounded by MAX_OUTSTANDING.
- Sits between narrow Lite peripherals/CSR masters and the wide AXI fabric.

Parameters:
ADDR_WIDTH, 48, address width; must equal both interfaces' ADDR_WIDTH.
LITE_DATA_WIDTH, 32, Lite data width; power of two, >= 8.
DATA_WIDTH, 64, AXI data width; power of two, >= LITE_DATA_WIDTH.
MAX_OUTSTANDING, 4, maximum in-flight reads and, separately, in-flight writes; >= 1.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-high reset.
master  axi_lite_channel.slave  interface  Lite side, width LITE_DATA_WIDTH.
slave  axi_channel.master  interface  AXI side, width DATA_WIDTH.

Behaviour:
- Elaboration-time $fatal if any of these fail:
  - ADDR_WIDTH matches both interfaces.
  - Interface data widths match the parameters.
  - DATA_WIDTH >= LITE_DATA_WIDTH.
- Derived values:
  - RATIO = DATA_WIDTH/LITE_DATA_WIDTH.
  - LB = $clog2(LITE_DATA_WIDTH/8).
  - lane = addr[$clog2(DATA_WIDTH/8)-1:LB]; lane is constant 0 when RATIO==1.
- Fixed AXI attributes on both AW and AR:
  - id='0, len=0, size=LB, burst=INCR, lock=0, cache=0, qos=0, region=0, user='0.
  - addr and prot pass through; w_last=1, w_user='0.
- Write path. State = lane FIFO wq (depth MAX_OUTSTANDING) plus write counter wcnt (0..MAX_OUTSTANDING).
  - slave.aw_valid = master.aw_valid && wcnt<MAX_OUTSTANDING; master.aw_ready = slave.aw_ready under the same gate.
  - On the AW handshake: push lane into wq and increment wcnt.
  - slave.w_valid = master.w_valid && !wq.empty; master.w_ready = slave.w_ready && !wq.empty. W is never forwarded ahead of its AW; a W arriving first waits.
  - w_data = master.w_data replicated across all RATIO lanes.
  - w_strb = master.w_strb in lane wq.head; all other strobes are 0.
  - On the W handshake: pop wq.
  - B passes through (resp, valid, ready); b_id and b_user are dropped.
  - On the B handshake: decrement wcnt.
  - AW and B handshakes in the same cycle: wcnt unchanged.
- Read path. State = lane FIFO rq (depth MAX_OUTSTANDING).
  - slave.ar_valid = master.ar_valid && !rq.full; master.ar_ready = slave.ar_ready && !rq.full.
  - On the AR handshake: push lane into rq.
  - master.r_data = slave.r_data[rq.head*LITE_DATA_WIDTH +: LITE_DATA_WIDTH]; r_resp, r_valid and r_ready pass through.
  - On the R handshake: pop rq.
  - r_last, r_id and r_user are dropped.
- Full/empty rules:
  - Full is based on registered occupancy. No push happens while full, even if a pop occurs in the same cycle. A push while non-full and a pop in the same cycle keep occupancy constant.
  - slave.r_valid while rq is empty is a protocol violation: assertion fires, and data is taken from lane 0.
  - slave.b_valid while wcnt==0 is a protocol violation: assertion fires.
- Reset (asynchronous, any time):
  - wq and rq are emptied and wcnt is cleared to 0.
  - Forwarded valids/readies are therefore ungated apart from the wq-empty gate on W.
  - There are no registered outputs; all outputs are combinational from the inputs plus this state.
  - In-flight transactions are abandoned; the environment must reset the slave simultaneously.
- Latency: zero cycles on every channel; no data is registered.

Test Plan:
- Parameters 32/64, MAX_OUTSTANDING=4. Write addr 0x1004, data 0xDEADBEEF, strb 0xF.
  - AW: addr 0x1004, size 2, len 0.
  - W: data 0xDEADBEEF_DEADBEEF, strb 0xF0, last=1.
  - B OKAY returned; wcnt returns to 0.
- W presented 3 cycles before AW (addr 0x2000): w_ready=0 and slave.w_valid=0 until the AW handshake; then W is forwarded with strb 0x0F.
- Five back-to-back reads (addr 0x0, 0x4, 0x8, 0xC, 0x10) with the slave withholding R:
  - The 5th AR stalls (ar_ready=0).
  - After the first R beat (0x11111111_22222222) the master sees 0x22222222, and the 5th AR is then accepted.
  - Subsequent beats select the upper, lower, upper and lower lanes in order.
- Five AWs with B withheld: the 5th is stalled. On the cycle where a B handshake and a new AW coincide at wcnt=4, no AW is accepted and wcnt drops to 3. AWs then resume.
- Reset asserted mid-read with 2 outstanding: the master sees ar_ready=slave.ar_ready immediately, and the rq count reads 0. A following read at 0x4 selects the upper lane.
- Parameters 64/64 (RATIO=1): data and strobes pass unmodified, and size=3.
